ram_using_inout_port: RTL and testbench



---
 rtl/ram_using_inout_port.sv | 63 ++++++
 tb/tb_ram_using_inout_port.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/ram_using_inout_port.sv
// Single-port synchronous RAM on a shared bidirectional data bus, with one-cycle read latency.
// Optional RAM_CLEAR_ON_RESET_EN: asynchronous reset also clears every memory word.
module ram_using_inout_port #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DEPTH      = 2 ** ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cs,
    input  logic                  wr,
    input  logic [ADDR_WIDTH-1:0] add,
    inout  wire  [DATA_WIDTH-1:0] data
);

    logic                  wr_en;
    logic                  rd_en;
    logic                  drive_en;
    logic [DATA_WIDTH-1:0] rdata_d;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_comb begin
        wr_en    = cs & wr;
        rd_en    = cs & ~wr;
        // Combinational enable so the bus is released in the same cycle wr rises.
        drive_en = rst_n & rd_en;
        rdata_d  = rdata_q;
        if (rd_en) begin
            rdata_d = mem_q[add];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

`ifdef RAM_CLEAR_ON_RESET_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[add] <= data;
        end
    end
`else
    // No reset on the array so it maps onto RAM; a write coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (rst_n && wr_en) begin
            mem_q[add] <= data;
        end
    end
`endif

    assign data = drive_en ? rdata_q : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_ram_using_inout_port.sv
// Randomised and directed bench for ram_using_inout_port with a word-level memory model.
// Bus release is probed by driving a known pattern that any RAM contention would corrupt.
module tb_ram_using_inout_port;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cs = 1'b0;
    logic       wr = 1'b0;
    logic [3:0] add = 4'd0;
    logic       tb_en = 1'b0;
    logic [7:0] tb_val = 8'h00;
    wire  [7:0] data;

    assign data = tb_en ? tb_val : 8'bzzzz_zzzz;

    int n_checks = 0;
    int n_fails  = 0;

    logic [7:0] ref_mem [16];
    logic [7:0] exp_rdata = 8'h00;
    logic [7:0] wvals [16];

    ram_using_inout_port #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(4),
        .DEPTH     (16)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .cs   (cs),
        .wr   (wr),
        .add  (add),
        .data (data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One bus cycle: reads show the previous read result; otherwise the bench drives the bus
    // (write data, or the complement of the held read data as a release probe).
    task automatic cycle(input logic c, input logic w, input logic [3:0] a,
                         input logic [7:0] d, input string tag);
        logic [7:0] exp;
        @(negedge clk);
        cs  = c;
        wr  = w;
        add = a;
        if (c && !w) begin
            tb_en = 1'b0;
            exp   = exp_rdata;
        end else begin
            tb_en  = 1'b1;
            tb_val = (c && w) ? d : ~exp_rdata;
            exp    = tb_val;
        end
        #1;
        check(tag, data, exp);
        @(posedge clk);
        if (c && w) ref_mem[a] = d;
        else if (c) exp_rdata = ref_mem[a];
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
`ifdef RAM_CLEAR_ON_RESET_EN
            ref_mem[i] = 8'h00;
`else
            ref_mem[i] = 8'hxx;
`endif
            wvals[i] = 8'($urandom);
        end
        wvals[0] = 8'h24;
        wvals[1] = 8'h81;
        wvals[2] = 8'h09;

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset: bus released, then rdata visible as 0 before any read edge.
        cycle(1'b0, 1'b0, 4'd0, 8'h00, "idle0");
        cycle(1'b0, 1'b1, 4'd7, 8'h00, "idle1");
        cycle(1'b1, 1'b1, 4'd0, wvals[0], "wr0");
        @(negedge clk);
        cs = 1'b0;
        // Show the reset rdata: enable read drive mid-cycle, no edge has loaded it yet.
        cs = 1'b1; wr = 1'b0; tb_en = 1'b0;
        #1;
        check("rdata_reset", data, 8'h00);
        cs = 1'b0; tb_en = 1'b1; tb_val = 8'hff;
        @(posedge clk);

        for (int i = 1; i < 16; i++) cycle(1'b1, 1'b1, 4'(i), wvals[i], "wr_sweep");
        for (int i = 15; i >= 0; i--) cycle(1'b1, 1'b0, 4'(i), 8'h00, "rd_sweep");
        cycle(1'b1, 1'b0, 4'd0, 8'h00, "rd_sweep_last");
        check("rd_add0", exp_rdata, 8'h24);

        // Read-after-write; the write cycle follows a read so release must be combinational.
        cycle(1'b1, 1'b1, 4'd3, 8'hA5, "raw_wr");
        cycle(1'b1, 1'b0, 4'd3, 8'h00, "raw_rd");
        cycle(1'b1, 1'b0, 4'd3, 8'h00, "raw_chk");

        // Unselected write must not land.
        cycle(1'b0, 1'b1, 4'd5, 8'hFF, "cs0_wr");
        cycle(1'b1, 1'b0, 4'd5, 8'h00, "cs0_rd");
        cycle(1'b1, 1'b0, 4'd5, 8'h00, "cs0_chk");

        // Reset mid-read, with a write attempted while reset is held.
        cycle(1'b1, 1'b0, 4'd3, 8'h00, "pre_rst_rd");
        @(negedge clk);
        cs = 1'b1; wr = 1'b0; add = 4'd3; tb_en = 1'b0;
        #1;
        check("pre_rst", data, 8'hA5);
        #1;
        tb_en = 1'b1; tb_val = 8'h00;
        rst_n = 1'b0;
        #1;
        check("rst_release", data, 8'h00);
        wr = 1'b1; tb_val = 8'h77;
        @(posedge clk);
        #1;
        check("rst_no_drive", data, 8'h77);
        @(negedge clk);
        exp_rdata = 8'h00;
`ifdef RAM_CLEAR_ON_RESET_EN
        for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
`endif
        cs = 1'b0; tb_val = 8'hff;
        rst_n = 1'b1;
        cycle(1'b1, 1'b0, 4'd3, 8'h00, "post_rst_rdata");
        cycle(1'b1, 1'b0, 4'd3, 8'h00, "post_rst_rd3");
`ifdef RAM_CLEAR_ON_RESET_EN
        check("post_rst_val", exp_rdata, 8'h00);
`else
        check("post_rst_val", exp_rdata, 8'hA5);
        // Repopulate so random reads never touch an unwritten word.
`endif
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b1, 4'(i), 8'($urandom), "refill");

        for (int k = 0; k < 300; k++) begin
            cycle(($urandom_range(3) != 0), 1'($urandom), 4'($urandom), 8'($urandom), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
